// File: rtl/life_sequencer_if.sv
// Board-side control, pattern-load handshake and engine strobe bundle for life_sequencer.
// master drives commands/patterns and the engine grid; slave is the sequencer.
interface life_sequencer_if;
    logic        cmd_run;
    logic        cmd_pause;
    logic        cmd_step;
    logic        load_valid;
    logic [63:0] load_data;
    logic        load_ready;
    logic [63:0] grid_in;
    logic        tick;
    logic        load_en;
    logic [63:0] load_grid;
    logic [15:0] gen_count;
    logic        stalled;
    logic        running;

    modport master (
        output cmd_run, cmd_pause, cmd_step, load_valid, load_data, grid_in,
        input  load_ready, tick, load_en, load_grid, gen_count, stalled, running
    );

    modport slave (
        input  cmd_run, cmd_pause, cmd_step, load_valid, load_data, grid_in,
        output load_ready, tick, load_en, load_grid, gen_count, stalled, running
    );
endinterface

// File: rtl/life_sequencer.sv
// Run/pause/step/load sequencer for the 8x8 Life engine: tick prescaler, generation count, stall detect.
// Define LIFE_AUTO_RESEED_EN to reseed from SEED_PATTERN on a stall in RUN instead of pausing.
module life_sequencer #(
    parameter int unsigned TICK_DIV     = 6000000,
    parameter int unsigned STALL_LIMIT  = 4,
    parameter logic [63:0] SEED_PATTERN = 64'h0000_0000_0007_0204
) (
    input  logic            clk,
    input  logic            rst_n,
    life_sequencer_if.slave bus
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TC  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    STALL_MAX = 4'(STALL_LIMIT);

`ifdef LIFE_AUTO_RESEED_EN
    typedef enum logic [1:0] {PAUSE, RUN, STEP, RESEED} state_t;

    function automatic logic [63:0] rotl64(input logic [63:0] v, input logic [5:0] sh);
        logic [127:0] t;
        t = {v, v} << sh;
        return t[127:64];
    endfunction
`else
    typedef enum logic [1:0] {PAUSE, RUN, STEP} state_t;
`endif

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    stall_cnt, stall_nxt;
    logic [63:0]   prev_grid;
    logic          tick_d, stall_hit;
    logic          tick_q, load_en_q, stalled_q, running_q;
    logic [63:0]   load_grid_q;
    logic [15:0]   gen_q;
    logic          load_acc;

    assign bus.load_ready = rst_n && (state == PAUSE) && !load_en_q;
    assign bus.tick       = tick_q;
    assign bus.load_en    = load_en_q;
    assign bus.load_grid  = load_grid_q;
    assign bus.gen_count  = gen_q;
    assign bus.stalled    = stalled_q;
    assign bus.running    = running_q;
    assign load_acc       = bus.load_valid && bus.load_ready;

    // Evaluated on the cycle after a tick, when grid_in already holds the new generation.
    always_comb begin
        stall_nxt = 4'd0;
        if (bus.grid_in == prev_grid || bus.grid_in == 64'd0)
            stall_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PAUSE;
            presc       <= '0;
            stall_cnt   <= 4'd0;
            prev_grid   <= 64'd0;
            tick_d      <= 1'b0;
            stall_hit   <= 1'b0;
            tick_q      <= 1'b0;
            load_en_q   <= 1'b0;
            stalled_q   <= 1'b0;
            running_q   <= 1'b0;
            load_grid_q <= 64'd0;
            gen_q       <= 16'd0;
        end else begin
            tick_q    <= 1'b0;
            load_en_q <= 1'b0;
            tick_d    <= tick_q;
            stall_hit <= 1'b0;
            if (tick_q) begin
                gen_q     <= (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
                prev_grid <= bus.grid_in;
            end
            if (tick_d) begin
                stall_cnt <= stall_nxt;
                stall_hit <= (stall_nxt == STALL_MAX);
                if (stall_nxt == STALL_MAX) stalled_q <= 1'b1;
            end
            // Later assignments below (load/reseed clears) override the bookkeeping above.
            case (state)
                PAUSE: begin
                    if (load_acc) begin
                        load_en_q   <= 1'b1;
                        load_grid_q <= bus.load_data;
                        gen_q       <= 16'd0;
                        stall_cnt   <= 4'd0;
                        stalled_q   <= 1'b0;
                    end else if (bus.cmd_step) begin
                        state <= STEP;
                    end else if (bus.cmd_run) begin
                        state     <= RUN;
                        presc     <= '0;
                        running_q <= 1'b1;
                    end
                end
                STEP: begin
                    tick_q <= 1'b1;
                    state  <= PAUSE;
                end
                RUN: begin
                    if (bus.cmd_pause) begin
                        state     <= PAUSE;
                        presc     <= '0;
                        running_q <= 1'b0;
                    end else if (stall_hit) begin
                        running_q <= 1'b0;
`ifdef LIFE_AUTO_RESEED_EN
                        state       <= RESEED;
                        load_en_q   <= 1'b1;
                        load_grid_q <= rotl64(SEED_PATTERN, gen_q[5:0]);
                        gen_q       <= 16'd0;
                        stall_cnt   <= 4'd0;
                        stalled_q   <= 1'b0;
                        presc       <= '0;
`else
                        state <= PAUSE;
`endif
                    end else if (presc == PRESC_TC) begin
                        presc  <= '0;
                        tick_q <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
`ifdef LIFE_AUTO_RESEED_EN
                RESEED: begin
                    state     <= RUN;
                    presc     <= '0;
                    running_q <= 1'b1;
                end
`endif
                default: begin
                    state     <= PAUSE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboarded bench for life_sequencer: expected tick/load events are queued when stimulus
// is driven and retired by a monitor as the DUT emits them; tasks check state inline.
module tb_life_sequencer;
    localparam int          TICK_DIV    = 4;
    localparam int          STALL_LIMIT = 2;
    localparam logic [63:0] SEED        = 64'h0000_0000_0007_0204;
    localparam logic [63:0] BLOCK       = 64'h0000_0000_0000_1818;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_tick_q[$];
    int          exp_load_cyc_q[$];
    logic [63:0] exp_load_grid_q[$];
    logic        frozen = 1'b0;
    logic [63:0] grid = 64'h1;

    life_sequencer_if bus();

    life_sequencer #(
        .TICK_DIV(TICK_DIV), .STALL_LIMIT(STALL_LIMIT), .SEED_PATTERN(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine stand-in: evolves on tick unless frozen (a still life), reloads on load_en.
    assign bus.grid_in = grid;
    always @(posedge clk) begin
        if (bus.load_en) grid <= bus.load_grid;
        else if (bus.tick && !frozen) grid <= grid + 64'h0001_0001;
    end

    always @(negedge clk) begin : monitor
        int          t;
        logic [63:0] g;
        if (rst_n) begin
            if (bus.tick) begin
                checks++;
                if (exp_tick_q.size() == 0) begin
                    errors++; $display("FAIL tick_unexpected cycle=%0d", cyc);
                end else begin
                    t = exp_tick_q.pop_front();
                    if (cyc !== t) begin
                        errors++; $display("FAIL tick_cycle got=%0d exp=%0d", cyc, t);
                    end
                end
            end
            if (bus.load_en) begin
                checks++;
                if (exp_load_cyc_q.size() == 0) begin
                    errors++; $display("FAIL load_unexpected cycle=%0d grid=%h", cyc, bus.load_grid);
                end else begin
                    t = exp_load_cyc_q.pop_front();
                    g = exp_load_grid_q.pop_front();
                    if (cyc !== t || bus.load_grid !== g) begin
                        errors++;
                        $display("FAIL load_event got cyc=%0d grid=%h exp cyc=%0d grid=%h", cyc, bus.load_grid, t, g);
                    end
                end
            end
            if (bus.tick && bus.load_en) begin
                checks++; errors++; $display("FAIL tick_and_load_en cycle=%0d", cyc);
            end
        end
    end

    task automatic step_to(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic push_load(input int c, input logic [63:0] g);
        exp_load_cyc_q.push_back(c);
        exp_load_grid_q.push_back(g);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_tick_q.size() != 0 || exp_load_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending ticks=%0d loads=%0d exp 0", name, exp_tick_q.size(), exp_load_cyc_q.size());
        end
    endtask

    task automatic test_reset();
        step_to(2); @(negedge clk);
        checks++;
        if ({bus.tick, bus.load_en, bus.stalled, bus.running, bus.load_ready, bus.gen_count} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got tick=%b load_en=%b stalled=%b running=%b ready=%b gen=%0d exp all 0",
                     bus.tick, bus.load_en, bus.stalled, bus.running, bus.load_ready, bus.gen_count);
        end
        checks++;
        if (bus.load_grid !== 64'd0) begin errors++; $display("FAIL reset_load_grid got=%h exp 0", bus.load_grid); end
        step_to(3); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp 1", bus.load_ready); end
    endtask

    task automatic test_run();
        step_to(10);
        bus.cmd_run = 1'b1;
        exp_tick_q.push_back(15); exp_tick_q.push_back(19); exp_tick_q.push_back(23);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(12); bus.cmd_step = 1'b1; next_cyc(); bus.cmd_step = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.running !== 1'b1 || bus.load_ready !== 1'b0) begin
            errors++; $display("FAIL run_flags got running=%b ready=%b exp 1 0", bus.running, bus.load_ready);
        end
        step_to(24); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd3) begin errors++; $display("FAIL run_gen_count got=%0d exp 3", bus.gen_count); end
        check_drained("run");
        step_to(25); bus.cmd_pause = 1'b1; next_cyc(); bus.cmd_pause = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.running !== 1'b0) begin errors++; $display("FAIL run_pause_running got=%b exp 0", bus.running); end
    endtask

    task automatic test_load();
        int d;
        d = cyc + 2;
        step_to(d);
        bus.load_valid = 1'b1; bus.load_data = 64'h0000_0000_0007_0000;
        push_load(d + 1, 64'h0000_0000_0007_0000);
        @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_pause got=%b exp 1", bus.load_ready); end
        next_cyc(); bus.load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd0 || bus.load_ready !== 1'b0) begin
            errors++; $display("FAIL load_after got gen=%0d ready=%b exp 0 0", bus.gen_count, bus.load_ready);
        end
        step_to(d + 2); @(negedge clk);
        check_drained("load");
    endtask

    task automatic test_step();
        int e;
        e = cyc + 2;
        step_to(e); bus.cmd_step = 1'b1; exp_tick_q.push_back(e + 2);
        next_cyc(); bus.cmd_step = 1'b0;
        step_to(e + 3); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd1 || bus.running !== 1'b0 || bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL step_one got gen=%0d running=%b ready=%b exp 1 0 1", bus.gen_count, bus.running, bus.load_ready);
        end
        step_to(e + 4); bus.cmd_step = 1'b1; exp_tick_q.push_back(e + 6);
        next_cyc(); bus.cmd_step = 1'b0;
        step_to(e + 7); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd2) begin errors++; $display("FAIL step_two got gen=%0d exp 2", bus.gen_count); end
        check_drained("step");
    endtask

    task automatic test_pause_tc();
        int f;
        int g;
        f = cyc + 2;
        step_to(f); bus.cmd_run = 1'b1; exp_tick_q.push_back(f + 5);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(f + 8); bus.cmd_pause = 1'b1;   // prescaler terminal-count cycle
        next_cyc(); bus.cmd_pause = 1'b0;
        step_to(f + 12); @(negedge clk);
        checks++;
        if (bus.running !== 1'b0 || bus.gen_count !== 16'd3) begin
            errors++; $display("FAIL pause_tc got running=%b gen=%0d exp 0 3", bus.running, bus.gen_count);
        end
        check_drained("pause_tc");
        g = f + 14;
        step_to(g); bus.cmd_run = 1'b1; exp_tick_q.push_back(g + 5);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(g + 6); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd4) begin errors++; $display("FAIL pause_restart_gen got=%0d exp 4", bus.gen_count); end
        step_to(g + 7); bus.cmd_pause = 1'b1; next_cyc(); bus.cmd_pause = 1'b0;
        step_to(g + 9); @(negedge clk);
        check_drained("pause_restart");
    endtask

    task automatic test_stall();
        int h;
        int q;
        frozen = 1'b1;
        h = cyc + 2;
        step_to(h); bus.load_valid = 1'b1; bus.load_data = BLOCK; push_load(h + 1, BLOCK);
        next_cyc(); bus.load_valid = 1'b0;
        step_to(h + 3); bus.cmd_run = 1'b1;
        exp_tick_q.push_back(h + 8); exp_tick_q.push_back(h + 12);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(h + 14); @(negedge clk);
        checks++;
        if (bus.stalled !== 1'b1 || bus.running !== 1'b1 || bus.gen_count !== 16'd2) begin
            errors++;
            $display("FAIL stall_detect got stalled=%b running=%b gen=%0d exp 1 1 2", bus.stalled, bus.running, bus.gen_count);
        end
`ifdef LIFE_AUTO_RESEED_EN
        push_load(h + 15, 64'h0000_0000_001C_0810);
        exp_tick_q.push_back(h + 20);
        step_to(h + 15); @(negedge clk);
        checks++;
        if (bus.stalled !== 1'b0 || bus.gen_count !== 16'd0) begin
            errors++; $display("FAIL reseed_clear got stalled=%b gen=%0d exp 0 0", bus.stalled, bus.gen_count);
        end
        step_to(h + 21); @(negedge clk);
        checks++;
        if (bus.running !== 1'b1 || bus.gen_count !== 16'd1) begin
            errors++; $display("FAIL reseed_run got running=%b gen=%0d exp 1 1", bus.running, bus.gen_count);
        end
        step_to(h + 22); bus.cmd_pause = 1'b1; next_cyc(); bus.cmd_pause = 1'b0;
        step_to(h + 24); @(negedge clk);
        check_drained("reseed");
`else
        step_to(h + 15); @(negedge clk);
        checks++;
        if (bus.running !== 1'b0 || bus.stalled !== 1'b1 || bus.gen_count !== 16'd2) begin
            errors++;
            $display("FAIL stall_pause got running=%b stalled=%b gen=%0d exp 0 1 2", bus.running, bus.stalled, bus.gen_count);
        end
        step_to(h + 21); @(negedge clk);
        checks++;
        if (bus.stalled !== 1'b1 || bus.load_ready !== 1'b1) begin
            errors++; $display("FAIL stall_sticky got stalled=%b ready=%b exp 1 1", bus.stalled, bus.load_ready);
        end
        check_drained("stall");
`endif
        frozen = 1'b0;
        q = cyc + 1;
        step_to(q); bus.load_valid = 1'b1; bus.load_data = 64'h0000_0000_0000_0E00;
        push_load(q + 1, 64'h0000_0000_0000_0E00);
        next_cyc(); bus.load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stalled !== 1'b0) begin errors++; $display("FAIL stall_cleared_by_load got=%b exp 0", bus.stalled); end
    endtask

    task automatic test_back_to_back();
        int d;
        d = cyc + 2;
        step_to(d);
        bus.load_valid = 1'b1; bus.load_data = 64'h0000_0000_0070_0000; bus.cmd_step = 1'b1;
        push_load(d + 1, 64'h0000_0000_0070_0000);
        next_cyc();
        bus.cmd_step = 1'b0; bus.load_data = 64'h0000_0000_0000_0C0C;
        @(negedge clk);
        checks++;
        if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%b exp 0", bus.load_ready); end
        next_cyc();
        push_load(d + 3, 64'h0000_0000_0000_0C0C);
        next_cyc(); bus.load_valid = 1'b0;
        step_to(d + 6); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd0) begin errors++; $display("FAIL b2b_gen got=%0d exp 0", bus.gen_count); end
        check_drained("b2b");
    endtask

    task automatic test_reset_mid_run();
        int k;
        int m;
        k = cyc + 2;
        step_to(k); bus.cmd_run = 1'b1; exp_tick_q.push_back(k + 5);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(k + 7); rst_n = 1'b0; #1;
        checks++;
        if ({bus.tick, bus.load_en, bus.stalled, bus.running, bus.load_ready, bus.gen_count} !== 21'd0
            || bus.load_grid !== 64'd0) begin
            errors++;
            $display("FAIL midrun_reset got running=%b ready=%b gen=%0d grid=%h exp all 0",
                     bus.running, bus.load_ready, bus.gen_count, bus.load_grid);
        end
        step_to(k + 9); rst_n = 1'b1;
        step_to(k + 15); @(negedge clk);
        checks++;
        if (bus.running !== 1'b0 || bus.load_ready !== 1'b1 || bus.gen_count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_release got running=%b ready=%b gen=%0d exp 0 1 0", bus.running, bus.load_ready, bus.gen_count);
        end
        check_drained("midrun");
        m = k + 16;
        step_to(m); bus.cmd_run = 1'b1; exp_tick_q.push_back(m + 5);
        next_cyc(); bus.cmd_run = 1'b0;
        step_to(m + 6); @(negedge clk);
        checks++;
        if (bus.gen_count !== 16'd1) begin errors++; $display("FAIL midrun_rerun_gen got=%0d exp 1", bus.gen_count); end
        step_to(m + 7); bus.cmd_pause = 1'b1; next_cyc(); bus.cmd_pause = 1'b0;
        step_to(m + 9); @(negedge clk);
        check_drained("midrun_rerun");
    endtask

    initial begin
        bus.cmd_run = 1'b0; bus.cmd_pause = 1'b0; bus.cmd_step = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = 64'd0;
        test_reset();
        test_run();
        test_load();
        test_step();
        test_pause_tc();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
